// File: rtl/dpll_pkg.sv
// Shared constants, literal helpers and the streamer state encoding for the DPLL literal-stream blocks.
package dpll_pkg;

    localparam int LIT_END = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } streamer_state_e;

    function automatic int lit_width(input int width);
        return width + 32'sd1;
    endfunction

    function automatic int var_index(input int lit);
        return (lit < 32'sd0) ? -lit : lit;
    endfunction

endpackage

// File: rtl/clause_mem.sv
// Clause database storage: synchronous write port, combinational read port.
module clause_mem #(
    parameter int LW     = 5,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [LW-1:0]     wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [LW-1:0]     rdata
);

    logic [LW-1:0] mem_r [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/literal_streamer.sv
// Replays the stored CNF clause database as a literal stream with reduced-form flags.
// Build option: SKIP_SATISFIED_EN suppresses literals that are not in reduced form.
module literal_streamer
    import dpll_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int OUT_SIZE = 16,
    parameter int DEPTH    = 64,
    parameter int ADDR_W   = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load_valid,
    input  logic [WIDTH:0]      load_literal,
    output logic                load_ready,
    output logic                overflow,
    input  logic                clear_db,
    input  logic                start,
    input  logic [OUT_SIZE-1:0] assign_true,
    input  logic [OUT_SIZE-1:0] assign_false,
    output logic                busy,
    output logic [WIDTH:0]      literal_out,
    output logic                literal_valid,
    output logic                literal_in_reduced_form,
    output logic                inputs_over
);

    localparam int              LW       = lit_width(WIDTH);
    localparam logic [LW-1:0]   MARKER   = LIT_END[LW-1:0];
    localparam logic [LW-1:0]   MOST_NEG = {1'b1, {WIDTH{1'b0}}};
    localparam logic [ADDR_W:0] PTR_ZERO = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W:0] PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] DEPTH_C  = DEPTH[ADDR_W:0];

    // {T, F} for the literal's variable; true wins, out-of-range and -2^WIDTH count as unassigned
    function automatic logic [1:0] lookup(input logic [LW-1:0] lit,
                                          input logic [OUT_SIZE-1:0] t,
                                          input logic [OUT_SIZE-1:0] f);
        int   v;
        logic t_bit;
        logic f_bit;
        v     = var_index(int'($signed(lit)));
        t_bit = 1'b0;
        f_bit = 1'b0;
        if (lit != MOST_NEG) begin
            for (int i = 0; i < OUT_SIZE; i++) begin
                if (i == v) begin
                    t_bit = t[i];
                    f_bit = f[i] & ~t[i];
                end
            end
        end
        return {t_bit, f_bit};
    endfunction

    function automatic logic lit_is_true(input logic [LW-1:0] lit, input logic [1:0] tf);
        return lit[LW-1] ? tf[0] : tf[1];
    endfunction

    function automatic logic lit_is_false(input logic [LW-1:0] lit, input logic [1:0] tf);
        return lit[LW-1] ? tf[1] : tf[0];
    endfunction

    streamer_state_e     state_r;
    logic [ADDR_W:0]     len_r;
    logic [ADDR_W:0]     cs_r;
    logic [ADDR_W:0]     ptr_r;
    logic [ADDR_W:0]     end_r;
    logic                sat_r;
    logic [LW-1:0]       first_lit_r;
    logic [OUT_SIZE-1:0] t_r;
    logic [OUT_SIZE-1:0] f_r;
    logic                load_ready_r;
    logic                overflow_r;
    logic                busy_r;
    logic [LW-1:0]       literal_out_r;
    logic                literal_valid_r;
    logic                reduced_r;
    logic                inputs_over_r;

    logic                we_s;
    logic [LW-1:0]       rd_data_s;
    logic                at_end_s;
    logic                cur_true_s;
    logic                cur_rf_s;
    logic                first_rf_s;
    logic                cur_valid_s;
    logic                first_valid_s;

    assign we_s = (state_r == IDLE) && !start && !clear_db && load_valid && load_ready_r;

    clause_mem #(
        .LW     (LW),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clause_mem (
        .clk   (clk),
        .we    (we_s),
        .waddr (len_r[ADDR_W-1:0]),
        .wdata (load_literal),
        .raddr (ptr_r[ADDR_W-1:0]),
        .rdata (rd_data_s)
    );

    // Literal evaluation against the snapshotted assignment
    always_comb begin
        at_end_s   = (ptr_r >= len_r) || (rd_data_s == MARKER);
        cur_true_s = lit_is_true(rd_data_s, lookup(rd_data_s, t_r, f_r));
        cur_rf_s   = !sat_r && !lit_is_false(rd_data_s, lookup(rd_data_s, t_r, f_r));
        first_rf_s = !sat_r && !lit_is_false(first_lit_r, lookup(first_lit_r, t_r, f_r));
`ifdef SKIP_SATISFIED_EN
        cur_valid_s   = cur_rf_s;
        first_valid_s = first_rf_s;
`else
        cur_valid_s   = 1'b1;
        first_valid_s = 1'b1;
`endif
    end

    // Pass sequencing, database bookkeeping and registered stream outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r         <= IDLE;
            len_r           <= PTR_ZERO;
            cs_r            <= PTR_ZERO;
            ptr_r           <= PTR_ZERO;
            end_r           <= PTR_ZERO;
            sat_r           <= 1'b0;
            first_lit_r     <= {LW{1'b0}};
            t_r             <= {OUT_SIZE{1'b0}};
            f_r             <= {OUT_SIZE{1'b0}};
            load_ready_r    <= 1'b0;
            overflow_r      <= 1'b0;
            busy_r          <= 1'b0;
            literal_out_r   <= {LW{1'b0}};
            literal_valid_r <= 1'b0;
            reduced_r       <= 1'b0;
            inputs_over_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        t_r          <= assign_true;
                        f_r          <= assign_false;
                        cs_r         <= PTR_ZERO;
                        ptr_r        <= PTR_ZERO;
                        sat_r        <= 1'b0;
                        busy_r       <= 1'b1;
                        load_ready_r <= 1'b0;
                        if (len_r == PTR_ZERO) begin
                            state_r       <= DONE;
                            inputs_over_r <= 1'b1;
                        end else begin
                            state_r <= SCAN;
                        end
                    end else if (clear_db) begin
                        len_r        <= PTR_ZERO;
                        overflow_r   <= 1'b0;
                        load_ready_r <= (PTR_ZERO < DEPTH_C);
                    end else if (load_valid && load_ready_r) begin
                        len_r        <= len_r + PTR_ONE;
                        load_ready_r <= ((len_r + PTR_ONE) < DEPTH_C);
                    end else begin
                        if (load_valid && (len_r >= DEPTH_C)) begin
                            overflow_r <= 1'b1;
                        end
                        load_ready_r <= (len_r < DEPTH_C);
                    end
                end
                SCAN: begin
                    if (!at_end_s) begin
                        sat_r <= sat_r | cur_true_s;
                        if (ptr_r == cs_r) begin
                            first_lit_r <= rd_data_s;
                        end
                        ptr_r <= ptr_r + PTR_ONE;
                    end else if (ptr_r == cs_r) begin
                        // Empty clause: skip its marker without emitting
                        cs_r  <= ptr_r + PTR_ONE;
                        ptr_r <= ptr_r + PTR_ONE;
                        sat_r <= 1'b0;
                        if ((ptr_r + PTR_ONE) >= len_r) begin
                            state_r       <= DONE;
                            inputs_over_r <= 1'b1;
                        end else begin
                            state_r <= SCAN;
                        end
                    end else begin
                        // First literal was captured during the scan so it can go out now
                        state_r         <= EMIT;
                        end_r           <= ptr_r;
                        ptr_r           <= cs_r + PTR_ONE;
                        literal_out_r   <= first_lit_r;
                        literal_valid_r <= first_valid_s;
                        reduced_r       <= first_rf_s;
                    end
                end
                EMIT: begin
                    if (ptr_r < end_r) begin
                        literal_out_r   <= rd_data_s;
                        literal_valid_r <= cur_valid_s;
                        reduced_r       <= cur_rf_s;
                        ptr_r           <= ptr_r + PTR_ONE;
                    end else begin
                        literal_out_r   <= {LW{1'b0}};
                        literal_valid_r <= 1'b0;
                        reduced_r       <= 1'b0;
                        cs_r            <= end_r + PTR_ONE;
                        ptr_r           <= end_r + PTR_ONE;
                        sat_r           <= 1'b0;
                        if ((end_r + PTR_ONE) >= len_r) begin
                            state_r       <= DONE;
                            inputs_over_r <= 1'b1;
                        end else begin
                            state_r <= SCAN;
                        end
                    end
                end
                DONE: begin
                    inputs_over_r <= 1'b0;
                    busy_r        <= 1'b0;
                    load_ready_r  <= (len_r < DEPTH_C);
                    state_r       <= IDLE;
                end
                default: begin
                    state_r         <= IDLE;
                    literal_valid_r <= 1'b0;
                    inputs_over_r   <= 1'b0;
                    busy_r          <= 1'b0;
                end
            endcase
        end
    end

    assign load_ready              = load_ready_r;
    assign overflow                = overflow_r;
    assign busy                    = busy_r;
    assign literal_out             = literal_out_r;
    assign literal_valid           = literal_valid_r;
    assign literal_in_reduced_form = reduced_r;
    assign inputs_over             = inputs_over_r;

endmodule

// File: tb/tb_literal_streamer.sv
// Directed self-checking bench for literal_streamer (honours SKIP_SATISFIED_EN when defined).
module tb_literal_streamer;

    localparam int WIDTH    = 4;
    localparam int OUT_SIZE = 16;
    localparam int DEPTH    = 64;
    localparam int ADDR_W   = 6;

    logic                clk = 1'b0;
    logic                reset;
    logic                load_valid;
    logic [WIDTH:0]      load_literal;
    logic                load_ready;
    logic                overflow;
    logic                clear_db;
    logic                start;
    logic [OUT_SIZE-1:0] assign_true;
    logic [OUT_SIZE-1:0] assign_false;
    logic                busy;
    logic [WIDTH:0]      literal_out;
    logic                literal_valid;
    logic                literal_in_reduced_form;
    logic                inputs_over;

    always #5 clk = ~clk;

    literal_streamer #(
        .WIDTH    (WIDTH),
        .OUT_SIZE (OUT_SIZE),
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .load_valid              (load_valid),
        .load_literal            (load_literal),
        .load_ready              (load_ready),
        .overflow                (overflow),
        .clear_db                (clear_db),
        .start                   (start),
        .assign_true             (assign_true),
        .assign_false            (assign_false),
        .busy                    (busy),
        .literal_out             (literal_out),
        .literal_valid           (literal_valid),
        .literal_in_reduced_form (literal_in_reduced_form),
        .inputs_over             (inputs_over)
    );

    typedef struct {
        logic       start;
        logic       valid;
        logic [4:0] lit;
        logic       rf;
        logic       io;
        logic       busy;
    } vec_t;

    vec_t       tv [13];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [4:0] got_lit [$];
    logic       got_rf  [$];
    logic [4:0] exp_lit [$];
    logic       exp_rf  [$];
    int         io_cnt;
    int         io_cyc;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [4:0] lit);
        load_valid   = 1'b1;
        load_literal = lit;
        tick();
        load_valid   = 1'b0;
    endtask

    task automatic do_clear();
        clear_db = 1'b1;
        tick();
        clear_db = 1'b0;
    endtask

    task automatic expect_lit(input logic [4:0] lit, input logic rf);
`ifdef SKIP_SATISFIED_EN
        if (rf) begin
            exp_lit.push_back(lit);
            exp_rf.push_back(rf);
        end
`else
        exp_lit.push_back(lit);
        exp_rf.push_back(rf);
`endif
    endtask

    // Start at cycle 0, optionally re-pulse start at cycle restart_at, collect for a fixed window
    task automatic run_pass(input int restart_at, input int window);
        got_lit.delete();
        got_rf.delete();
        io_cnt = 0;
        io_cyc = -1;
        start  = 1'b1;
        tick();
        for (int c = 1; c < window; c++) begin
            start = (c == restart_at);
            if (literal_valid) begin
                got_lit.push_back(literal_out);
                got_rf.push_back(literal_in_reduced_form);
            end
            if (inputs_over) begin
                io_cnt++;
                io_cyc = c;
            end
            tick();
        end
        start = 1'b0;
    endtask

    task automatic check_stream(input string name, input int exp_io_cyc);
        check($sformatf("%s literal count", name), 32'(got_lit.size()), 32'(exp_lit.size()));
        for (int i = 0; i < got_lit.size() && i < exp_lit.size(); i++) begin
            check($sformatf("%s literal %0d", name, i), 32'({got_lit[i], got_rf[i]}),
                  32'({exp_lit[i], exp_rf[i]}));
        end
        check($sformatf("%s inputs_over count", name), 32'(io_cnt), 32'd1);
        check($sformatf("%s inputs_over cycle", name), 32'(io_cyc), 32'(exp_io_cyc));
        exp_lit.delete();
        exp_rf.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       ev;
        logic [8:0] exp_w;
        logic [8:0] got_w;
        logic       io_seen;

        reset        = 1'b0;
        load_valid   = 1'b0;
        load_literal = 5'd0;
        clear_db     = 1'b0;
        start        = 1'b0;
        assign_true  = 16'h0000;
        assign_false = 16'h0000;
        tick();
        tick();
        check("reset outputs", 32'({load_ready, overflow, busy, literal_valid, literal_out,
                                   literal_in_reduced_form, inputs_over}), 32'd0);
        reset = 1'b1;
        tick();
        check("load_ready after reset", 32'(load_ready), 32'd1);

        // Pass 1: {1,-2} satisfied by x1, {2,3} open; assignment changed after start must not matter
        load(5'd1); load(5'b11110); load(5'd0); load(5'd2); load(5'd3); load(5'd0);
        assign_true  = 16'h0002;
        assign_false = 16'h0000;
        tv[0]  = '{1'b1, 1'b0, 5'd0,     1'b0, 1'b0, 1'b0};
        tv[1]  = '{1'b0, 1'b0, 5'd0,     1'b0, 1'b0, 1'b1};
        tv[2]  = '{1'b0, 1'b0, 5'd0,     1'b0, 1'b0, 1'b1};
        tv[3]  = '{1'b0, 1'b0, 5'd0,     1'b0, 1'b0, 1'b1};
        tv[4]  = '{1'b0, 1'b1, 5'd1,     1'b0, 1'b0, 1'b1};
        tv[5]  = '{1'b0, 1'b1, 5'b11110, 1'b0, 1'b0, 1'b1};
        tv[6]  = '{1'b0, 1'b0, 5'd0,     1'b0, 1'b0, 1'b1};
        tv[7]  = '{1'b0, 1'b0, 5'd0,     1'b0, 1'b0, 1'b1};
        tv[8]  = '{1'b0, 1'b0, 5'd0,     1'b0, 1'b0, 1'b1};
        tv[9]  = '{1'b0, 1'b1, 5'd2,     1'b1, 1'b0, 1'b1};
        tv[10] = '{1'b0, 1'b1, 5'd3,     1'b1, 1'b0, 1'b1};
        tv[11] = '{1'b0, 1'b0, 5'd0,     1'b0, 1'b1, 1'b1};
        tv[12] = '{1'b0, 1'b0, 5'd0,     1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 13; i++) begin
            start = tv[i].start;
            ev    = tv[i].valid;
`ifdef SKIP_SATISFIED_EN
            ev    = ev & tv[i].rf;
`endif
            exp_w = {ev, ev ? tv[i].lit : 5'd0, ev ? tv[i].rf : 1'b0, tv[i].io, tv[i].busy};
            got_w = {literal_valid, literal_valid ? literal_out : 5'd0,
                     literal_valid ? literal_in_reduced_form : 1'b0, inputs_over, busy};
            check($sformatf("pass1 cycle %0d", i), 32'(got_w), 32'(exp_w));
            tick();
            if (i == 0) begin
                assign_true  = 16'h0000;
                assign_false = 16'hFFFF;
            end
        end
        start = 1'b0;

        // Pass 2: {-1,4},{-4} with x4 false; start re-pulsed mid-pass must be ignored
        do_clear();
        load(5'b11111); load(5'd4); load(5'd0); load(5'b11100); load(5'd0);
        assign_true  = 16'h0000;
        assign_false = 16'h0010;
        expect_lit(5'b11111, 1'b1);
        expect_lit(5'd4,     1'b0);
        expect_lit(5'b11100, 1'b0);
        run_pass(3, 20);
        check_stream("pass2", 9);

        // Empty database, start while busy in DONE
        assign_false = 16'h0000;
        do_clear();
        run_pass(1, 10);
        check_stream("empty", 1);

        // Overflow at DEPTH
        for (int i = 0; i < DEPTH; i++) begin
            load(5'd1);
        end
        check("full: ready/overflow", 32'({load_ready, overflow}), 32'b00);
        load(5'd1);
        check("write when full: ready/overflow", 32'({load_ready, overflow}), 32'b01);
        do_clear();
        check("after clear: ready/overflow", 32'({load_ready, overflow}), 32'b10);

        // Leading empty clauses and missing final marker
        load(5'd0); load(5'd0); load(5'd5);
        expect_lit(5'd5, 1'b1);
        run_pass(-1, 20);
        check_stream("no marker", 6);

        // Reset mid-EMIT
        do_clear();
        load(5'd1); load(5'b11110); load(5'd0); load(5'd2); load(5'd3); load(5'd0);
        assign_true = 16'h0002;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        check("busy before mid-pass reset", 32'(busy), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("outputs during mid-pass reset", 32'({load_ready, overflow, busy, literal_valid, literal_out,
                                                   literal_in_reduced_form, inputs_over}), 32'd0);
        io_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            io_seen = io_seen | inputs_over;
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            io_seen = io_seen | inputs_over;
        end
        check("no inputs_over after reset abort", 32'(io_seen), 32'd0);
        run_pass(-1, 10);
        check_stream("after reset", 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/literal_streamer.md
Name: literal_streamer

Overview:
- Transmit side of the DPLL literal-stream interface.
- Holds the CNF clause database and, on start, replays every literal with a reduced-form flag computed against the current partial assignment. Ends each pass with an inputs_over pulse.
- Drives the literal stream consumed by the pure-literal detector and any other literal-stream consumers.

Parameters:
WIDTH, 4, variable-index bits; literals are signed two's complement, WIDTH+1 bits wide
OUT_SIZE, 16, assignment bitmap width; bit v = variable v, bit 0 unused
DEPTH, 64, clause memory entries, including end-of-clause markers
ADDR_W, 6, clog2(DEPTH)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
load_valid  in  1  database write strobe
load_literal  in  WIDTH+1  literal to store; 0 = end-of-clause marker
load_ready  out  1  high when a load is accepted this cycle
overflow  out  1  sticky: a write was attempted while memory was full
clear_db  in  1  empties the database (sets length to 0)
start  in  1  begin one streaming pass
assign_true  in  OUT_SIZE  variables assigned true
assign_false  in  OUT_SIZE  variables assigned false
busy  out  1  pass in progress
literal_out  out  WIDTH+1  streamed literal
literal_valid  out  1  literal_out is valid this cycle
literal_in_reduced_form  out  1  literal is still active in the reduced formula
inputs_over  out  1  one-cycle pulse after the last literal of a pass

Behaviour:
- Reset values: all outputs 0; database length 0; overflow 0; FSM in IDLE. Reset mid-pass aborts the pass with no inputs_over pulse, and the database is lost.
- Loading (IDLE only):
  - load_ready = (state==IDLE) && (len<DEPTH).
  - An accepted write goes to mem[len], and len increments.
  - A write while full sets overflow and is otherwise ignored.
  - clear_db in IDLE sets len=0 and overflow=0; clear_db outside IDLE is ignored.
- start:
  - Ignored unless IDLE.
  - Snapshots assign_true and assign_false into registers on the start cycle; later changes are ignored until the next pass.
- FSM states: IDLE -> SCAN -> EMIT -> SCAN ... -> DONE -> IDLE.
- SCAN:
  - Reads one entry per cycle from clause start cs.
  - Computes sat |= literal true. A literal is true if (lit>0 && T[v]) || (lit<0 && F[v]), with v=|lit|.
  - Ends on a marker or at len.
  - An empty clause (marker with no literals) goes straight to the next SCAN with no emission.
- EMIT:
  - Rewinds to cs and outputs one literal per cycle with literal_valid=1.
  - literal_in_reduced_form = !sat && !lit_false. A literal is false if (lit>0 && F[v]) || (lit<0 && T[v]).
  - After the last literal, cs = marker address + 1, then back to SCAN. If cs>=len, go to DONE.
- DONE: inputs_over=1 for exactly one cycle, busy drops the same cycle, then IDLE.
- Precedence and range rules:
  - If both T[v] and F[v] are set, true wins.
  - v>=OUT_SIZE is treated as unassigned.
  - The most-negative code (-2^WIDTH) is treated as unassigned.
- Timing:
  - Clause with k literals plus a marker: k+1 SCAN cycles, then k EMIT cycles.
  - len=0: start at T gives inputs_over at T+1 with no literals.
  - The final clause may omit its marker.
- busy=1 from the cycle after start through the DONE cycle.
- Outputs are registered; literal_valid=0 whenever not in EMIT.

Optional Feature:
- Macro: SKIP_SATISFIED_EN.
- Defined:
  - Literals with reduced_form=0 are suppressed (literal_valid=0 in that EMIT cycle), so every emitted literal has literal_in_reduced_form=1.
  - Cycle count is unchanged.
- Undefined: every stored literal is emitted, with its flag.

Decomposition:
- dpll_pkg:
  - constant LIT_END=0
  - literal width function (WIDTH+1)
  - streamer state enum {IDLE, SCAN, EMIT, DONE}
  - abs/var-index helper function
- One sub-module, clause_mem: DEPTH x (WIDTH+1) register file with a synchronous write port and a combinational read port.

Test Plan:
- Load 1,-2,0,2,3,0; T=0b0000_0010 (x1 true), F=0; start at cycle 0 -> 1(rf0) at cycle 4, -2(rf0) at cycle 5, 2(rf1) at cycle 9, 3(rf1) at cycle 10, inputs_over at cycle 11. With SKIP_SATISFIED_EN: only 2 and 3 are valid.
- Load -1,4,0,-4,0; F bit4 set -> -1 rf1, 4 rf0, -4 rf0 (clause -4 is satisfied); then inputs_over.
- Empty database: start -> inputs_over next cycle, literal_valid never asserted. Also issue start while busy -> ignored, exactly one inputs_over pulse.
- Write 65 loads with DEPTH=64 -> load_ready low after 64, overflow=1; clear_db -> len=0, overflow=0.
- Load 0,0,5 (no trailing marker) -> 5 emitted rf1, then inputs_over.
- Assert reset low mid-EMIT -> all outputs 0 immediately, no inputs_over pulse; after release, start -> immediate inputs_over (database cleared).
